sc_alaghi_nadder: RTL and testbench
===================================

Name: sc_alaghi_nadder

Overview:
- N-input scaled stochastic adder (Alaghi-style, no select streams). Each cycle it takes one bit from each of INPUT_STREAMS unipolar bitstreams and emits one output bit.
- Output stream probability = (sum of input probabilities) / INPUT_STREAMS.
- Counter/accumulator based, so the result is deterministic: no random select source.
- Sits in the stochastic-computing datapath after the SNG/bitstream sources and before the downstream SC operator or counter-based decoder.

Parameters:
- INPUT_STREAMS, 31: number of input bitstreams N; legal range ≥2.
- Derived (localparam) CW = clog2(N+1): width of the per-cycle ones count.
- Derived (localparam) AW = clog2(2N): width of the accumulator and sum.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- inpts, input, INPUT_STREAMS: one bit from each input stream, sampled every cycle.
- out, input/output direction output, 1: scaled-sum output stream bit, registered.

Behaviour:
- Stage 1 (popcount):
  - cnt_q <= number of 1s in inpts, range 0..N.
  - Popcount is a balanced adder tree and may be purely combinational before cnt_q.
- Stage 2 (accumulate/emit):
  - sum = acc_q + cnt_q, AW bits, max value 2N-1.
  - If sum ≥ N: out <= 1, acc_q <= sum - N.
  - Else: out <= 0, acc_q <= sum.
- acc_q invariant: always in 0..N-1. No overflow possible.
- Latency: inpts sampled at rising edge k affects out after edge k+1. out is stable for the cycle following edge k+1, i.e. a fixed 2-cycle pipeline (bench DELAY = 2).
- Throughput: one input vector and one output bit per cycle. No handshake and no stall.
- Reset (synchronous, rst=1 at an edge):
  - cnt_q=0, acc_q=0, out=0.
  - Inputs presented while rst=1 are discarded.
  - The first vector counted is the one sampled at the first edge with rst=0.
- Reset mid-operation: the accumulated residue is lost. The output stream restarts exactly as from power-on reset.
- Exactness: with S = total input ones counted since reset, the number of output ones emitted after the corresponding 2-cycle latency equals floor(S/N).
- N=2 special case: reduces to the classic toggle-flip-flop adder.
  - out = a&b, or out = (a^b) & T, where T toggles on each a^b event and starts at 0.
- No X propagation: every register is reset; no latches.

Test Plan:
- All zeros: rst held 8 cycles, then inpts=0 for 100 cycles -> out=0 every cycle, acc_q stays 0.
- All ones: inpts=all 31 bits set for 100 cycles -> cnt=31 each cycle. out=1 on every cycle from the 2nd cycle after reset release onward; out=0 during reset and for the first cycle after release.
- Single stream active: only inpts[0]=1 for 93 cycles -> out pulses exactly 3 times, once every 31 cycles. The first pulse appears 2 cycles after the 31st sampled vector.
- Half density: 16 bits set constantly for 31 cycles -> acc sequence 16, 1(out=1), 17, 2(out=1), … Output ones total 16 over those 31 results, matching floor(16·31/31).
- Mid-run reset: 10 random vectors, then rst=1 for 1 cycle, then all-ones -> out=0 during reset and the following cycle. The accumulator restarts from 0, with no carry-over from pre-reset residue.
- Random compare: 100 random 31-bit vectors checked against a reference model (acc/out per rule above, 2-cycle delay) -> zero mismatches. Cumulative output ones equal floor(S/31) at each point.

Source files
------------

// File: rtl/sc_alaghi_nadder.sv
// N-input scaled stochastic adder: popcount of the input bits feeds a modulo-N
// accumulator whose wrap-arounds form the output stream, so P(out) = sum(P(in)) / N.
module sc_alaghi_nadder #(
  parameter int INPUT_STREAMS = 31
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INPUT_STREAMS-1:0] inpts,
  output logic                     out
);

  localparam int CW     = $clog2(INPUT_STREAMS + 1);
  localparam int AW     = $clog2(2 * INPUT_STREAMS);
  localparam int LEVELS = (INPUT_STREAMS > 1) ? $clog2(INPUT_STREAMS) : 1;
  localparam int LEAVES = 1 << LEVELS;
  localparam int NODES  = 2 * LEAVES - 1;
  localparam logic [AW-1:0] N_AW = AW'(INPUT_STREAMS);

  // Heap-ordered adder tree: node 0 is the root, leaves start at LEAVES-1.
  // Every partial sum is bounded by N, so CW bits suffice at every level.
  logic [CW-1:0] node [0:NODES-1];

  genvar gi;
  generate
    for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
      if (gi < INPUT_STREAMS) begin : g_live
        assign node[LEAVES-1+gi] = CW'(inpts[gi]);
      end else begin : g_pad
        assign node[LEAVES-1+gi] = '0;
      end
    end
    for (gi = 0; gi < LEAVES - 1; gi++) begin : g_add
      assign node[gi] = node[2*gi+1] + node[2*gi+2];
    end
  endgenerate

  logic [CW-1:0] cnt_reg;
  logic [AW-1:0] acc_reg;
  logic [AW-1:0] acc_next;
  logic [AW-1:0] sum;
  logic          out_next;

  always_comb begin
    sum      = acc_reg + AW'(cnt_reg);
    acc_next = sum;
    out_next = 1'b0;
    if (sum >= N_AW) begin
      acc_next = sum - N_AW;
      out_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      acc_reg <= '0;
      out     <= 1'b0;
    end else begin
      cnt_reg <= node[0];
      acc_reg <= acc_next;
      out     <= out_next;
    end
  end

endmodule

// File: tb/tb_sc_alaghi_nadder.sv
// Bench for sc_alaghi_nadder: directed density patterns plus random vectors
// compared against a cumulative floor(S/N) model with two-cycle latency.
module tb_sc_alaghi_nadder;

  localparam int N = 31;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] inpts = '0;
  logic         out;

  sc_alaghi_nadder #(.INPUT_STREAMS(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .inpts (inpts),
    .out   (out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: S = ones accepted since reset; the vector sitting in the
  // popcount register carries the output bit it will produce next cycle.
  int s_tot      = 0;
  int stage_bit  = 0;
  int stage_pop  = 0;
  int ones_total = 0;

  // Per-segment statistics for the directed aggregate checks.
  int seg_ones  = 0;
  int seg_first = -1;
  int seg_idx   = 0;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic seg_start();
    seg_ones  = 0;
    seg_first = -1;
    seg_idx   = 0;
  endtask

  task automatic step(input logic r, input logic [N-1:0] v);
    int exp_out;
    int p;
    @(negedge clk);
    rst   = r;
    inpts = v;
    @(posedge clk);
    #1;
    if (r) begin
      exp_out   = 0;
      s_tot     = 0;
      stage_bit = 0;
      stage_pop = 0;
    end else begin
      exp_out   = stage_bit;
      p         = $countones(v);
      stage_bit = (s_tot + p) / N - s_tot / N;
      s_tot     = s_tot + p;
      stage_pop = p;
    end
    check("out", int'(out), exp_out);
    if (r) ones_total = 0;
    else if (out === 1'b1) ones_total++;
    if (!r) check("cum_ones", ones_total, (s_tot - stage_pop) / N);
    seg_idx++;
    if (out === 1'b1) begin
      seg_ones++;
      if (seg_first < 0) seg_first = seg_idx;
    end
    $display("[TB] rst=%0b inpts=%08h out=%0b exp=%0d S=%0d", r, v, out, exp_out, s_tot);
  endtask

  initial begin
    logic [N-1:0] all_ones;
    logic [N-1:0] half;
    all_ones = '1;
    half     = '0;
    for (int i = 0; i < 16; i++) half[i] = 1'b1;

    // Reset held 8 cycles with garbage inputs, which must be discarded.
    for (int i = 0; i < 8; i++) step(1'b1, N'($urandom));
    check("reset_out", int'(out), 0);

    // All zeros.
    seg_start();
    for (int i = 0; i < 100; i++) step(1'b0, '0);
    check("zeros_ones", seg_ones, 0);

    // All ones from a fresh reset: first result cycle is 0, then 1 forever.
    step(1'b1, '0);
    seg_start();
    for (int i = 0; i < 100; i++) step(1'b0, all_ones);
    check("ones_count", seg_ones, 99);
    check("ones_first", seg_first, 2);

    // Single active stream: one pulse per 31 vectors.
    step(1'b1, '0);
    seg_start();
    for (int i = 0; i < 93; i++) step(1'b0, N'(1));
    step(1'b0, '0);
    step(1'b0, '0);
    check("single_pulses", seg_ones, 3);
    check("single_first", seg_first, 32);

    // Half density: 16 of 31 bits set.
    step(1'b1, '0);
    seg_start();
    for (int i = 0; i < 31; i++) step(1'b0, half);
    step(1'b0, '0);
    step(1'b0, '0);
    check("half_ones", seg_ones, 16);

    // Mid-run reset: residue must not survive.
    for (int i = 0; i < 10; i++) step(1'b0, N'($urandom));
    step(1'b1, all_ones);
    check("midrst_during", int'(out), 0);
    seg_start();
    for (int i = 0; i < 20; i++) step(1'b0, all_ones);
    check("midrst_first", seg_first, 2);
    check("midrst_count", seg_ones, 19);

    // Random compare with varying densities.
    step(1'b1, '0);
    for (int i = 0; i < 100; i++) begin
      logic [N-1:0] v;
      int dens;
      dens = $urandom_range(0, 3);
      v = N'($urandom);
      if (dens == 0) v = v & N'($urandom);
      else if (dens == 1) v = v | N'($urandom);
      step(1'b0, v);
    end
    step(1'b0, '0);
    step(1'b0, '0);
    check("rand_final_cum", ones_total, s_tot / N);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
